load_input_file: RTL and testbench
==================================

// Module: load_input_file
//
// PURPOSE
//  Captures one input image of 784 1-bit pixels, delivered as 98 bytes (one byte per
//  trigger strobe, typically from a UART receiver), into internal storage.
//  Signals completion with a one-cycle ready pulse, then serves any pixel bit by
//  address as a registered 1-bit read port for the downstream network datapath.
//
// PARAMETERS
//  NUM_BYTES  98   bytes per image load
//  BYTE_W     8    bits per loaded byte
//  ADDR_W     10   bit-address width; 784 = NUM_BYTES*BYTE_W valid addresses
//
// PORTS
//  clk      in   1       single clock, all logic on rising edge
//  rst_n    in   1       reset, synchronous, active-low
//  trigger  in   1       one-cycle strobe: data holds the next byte of the image
//  data     in   8       byte to store; sampled only when trigger=1
//  addr     in   10      bit address for read port, 0..783
//  q        out  1       registered pixel bit at addr
//  ready    out  1       one-cycle pulse: full image (98th byte) stored
//
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): byte counter=0, ready=0, q=0. Storage contents
//    are not cleared.
//  - Write: at a rising edge with trigger=1, store data into byte slot byte_cnt.
//    Bit j of byte k goes to bit address 8*k+j (LSB first). Increment byte_cnt.
//  - Completion: on the edge that accepts byte index 97, byte_cnt wraps to 0 and
//    ready is registered high for exactly one cycle, driven from the edge after that
//    acceptance. Latency from the 98th trigger to ready=1: one cycle.
//  - ready is 0 at all other times, including during bytes 0..96 of every load.
//  - The next trigger after the wrap starts a new load at slot 0 and overwrites the
//    previous image byte by byte. A trigger in the same cycle as ready=1 is accepted
//    as byte 0.
//  - Read: at every rising edge, q <= mem[addr], using addr sampled at that edge.
//    Latency is one cycle. Reads are independent of the load state.
//  - Read/write collision, same bit on the same edge: q returns the old (pre-write)
//    value.
//  - addr >= 784: q <= 0.
//  - trigger held high for multiple cycles: each cycle is a separate byte. There is
//    no edge detection.
//  - Reset mid-load: counter returns to 0, so the partial image is discarded logically.
//
// STRUCTURE
//  - Shared package snn_pkg: NUM_BYTES, BYTE_W, ADDR_W, IMG_BITS=784, and the
//    byte-counter width (7 bits).
//  - One natural sub-module, input_bit_mem: 98x8 byte-write storage with a registered
//    1-bit read port.
//  - Top level: byte counter, wrap detection, ready register, read-port wiring.
//
// TESTING
//  1. Reset: rst_n low 1 cycle -> ready=0, q=0 afterwards.
//  2. Load 98 x 8'hFF, one trigger every 51 cycles -> ready stays 0 for bytes 0..96,
//     then pulses high exactly one cycle after byte 97 is accepted.
//  3. Read after load 2: sweep addr 0..783, one address per cycle -> q=1 every cycle,
//     one cycle after addr is applied.
//  4. Reload 98 x 8'h00 with no reset in between -> ready=0 at start, pulses once at
//     the end; sweep gives q=0 at all 784 addresses (full overwrite).
//  5. Load 98 x 8'b10011001, then sweep -> q at addr a equals bit (a mod 8) of the
//     byte. Repeat with 8'hC3 and 8'h93.
//  6. Edge cases:
//     - Assert rst_n after 40 bytes, then load 98 bytes -> ready pulses only after 98
//       post-reset bytes.
//     - addr=900 -> q=0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared sizing for the input-image loader: byte count, widths and pixel count.
package snn_pkg;
  localparam int NUM_BYTES = 98;
  localparam int BYTE_W    = 8;
  localparam int ADDR_W    = 10;
  localparam int IMG_BITS  = NUM_BYTES * BYTE_W;
  localparam int CNT_W     = 7;
  localparam int BSEL_W    = 3;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [CNT_W-1:0]  byte_idx_t;

  // Bit addresses past the last pixel read back as zero.
  function automatic logic addr_in_image(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(IMG_BITS);
  endfunction
endpackage

// File: rtl/input_bit_mem.sv
// 98x8 pixel storage: whole-byte writes, registered single-bit reads by bit address.
module input_bit_mem
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  byte_idx_t         i_waddr,
  input  byte_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              o_q
);
  byte_t     r_mem [NUM_BYTES];
  logic      r_q;
  byte_idx_t w_rbyte;
  logic [BSEL_W-1:0] w_rbit;
  byte_t     w_rd_byte;

  assign w_rbyte   = i_raddr[ADDR_W-1:BSEL_W];
  assign w_rbit    = i_raddr[BSEL_W-1:0];
  assign w_rd_byte = r_mem[w_rbyte];
  assign o_q       = r_q;

  // Storage is intentionally not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Same-edge write to the addressed bit returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (addr_in_image(i_raddr)) begin
      r_q <= w_rd_byte[w_rbit];
    end else begin
      r_q <= 1'b0;
    end
  end
endmodule

// File: rtl/load_input_file.sv
// Image loader: counts incoming bytes into pixel storage and pulses ready once
// the final byte of an image has been stored.
module load_input_file
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [7:0]        data,
  input  logic [ADDR_W-1:0] addr,
  output logic              q,
  output logic              ready
);
  byte_idx_t r_byte_cnt;
  logic      r_ready;
  logic      w_we;
  logic      w_last;

  assign w_we   = trigger && rst_n;
  assign w_last = trigger && (r_byte_cnt == CNT_W'(NUM_BYTES - 1));
  assign ready  = r_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= w_last;
      if (w_last) begin
        r_byte_cnt <= '0;
      end else if (trigger) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
    end
  end

  input_bit_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_byte_cnt),
    .i_wdata (data),
    .i_raddr (addr),
    .o_q     (q)
  );
endmodule

// File: tb/tb_load_input_file.sv
// Bench for load_input_file: pixel-array model plus directed loads and sweeps.
module tb_load_input_file;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trigger = 1'b0;
  logic [7:0] data = 8'h00;
  logic [9:0] addr = 10'd0;
  logic       q;
  logic       ready;

  int errs = 0;
  int checks = 0;
  int n_ready = 0;

  load_input_file dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (trigger),
    .data    (data),
    .addr    (addr),
    .q       (q),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Model: flat pixel array, byte counter, expected registered outputs.
  bit mem_v [784];
  bit mem_k [784];
  int m_cnt = 0;
  bit e_ready = 0, e_q = 0, e_q_k = 0, live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; e_ready = 0; e_q = 0; e_q_k = 1; live = 1;
    end else begin
      if (addr < 784) begin
        e_q = mem_v[addr]; e_q_k = mem_k[addr];
      end else begin
        e_q = 0; e_q_k = 1;
      end
      e_ready = 0;
      if (trigger) begin
        for (int j = 0; j < 8; j++) begin
          mem_v[m_cnt*8 + j] = data[j];
          mem_k[m_cnt*8 + j] = 1;
        end
        m_cnt++;
        if (m_cnt == 98) begin
          m_cnt = 0; e_ready = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("ready_model", 32'(ready), 32'(e_ready));
      if (e_q_k) chk("q_model", 32'(q), 32'(e_q));
    end
    if (ready === 1'b1) n_ready++;
  end

  task automatic load(input logic [7:0] b, input int n, input int gap, input bit last_ready);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); trigger = 1'b1; data = b;
      if (gap > 1) begin
        @(negedge clk); trigger = 1'b0;
        if (i == n - 1) chk("ready_latency", 32'(ready), 32'(last_ready));
        repeat (gap - 2) @(negedge clk);
      end
    end
    @(negedge clk); trigger = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep(output int ones);
    ones = 0;
    for (int a = 0; a <= 784; a++) begin
      @(negedge clk);
      if (a > 0 && q === 1'b1) ones++;
      if (a < 784) addr = 10'(a);
    end
    addr = 10'd0;
  endtask

  int ones, r0;

  initial begin
    // 1. reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_q", 32'(q), 32'd0);

    // 2/3. slow all-ones load, then sweep
    r0 = n_ready;
    load(8'hFF, 98, 51, 1'b1);
    chk("pulses_ff", 32'(n_ready - r0), 32'd1);
    sweep(ones);
    chk("ones_ff", 32'(ones), 32'd784);

    // 4. overwrite with zeros, trigger held high continuously
    r0 = n_ready;
    load(8'h00, 98, 1, 1'b1);
    chk("pulses_00", 32'(n_ready - r0), 32'd1);
    sweep(ones);
    chk("ones_00", 32'(ones), 32'd0);

    // 5. patterns
    r0 = n_ready;
    load(8'b10011001, 98, 3, 1'b1);
    chk("pulses_99", 32'(n_ready - r0), 32'd1);
    sweep(ones);
    chk("ones_99", 32'(ones), 32'd392);
    @(negedge clk); addr = 10'd3;
    @(negedge clk); chk("q_99_bit3", 32'(q), 32'd1);
    addr = 10'd1;
    @(negedge clk); chk("q_99_bit1", 32'(q), 32'd0);
    addr = 10'd783;
    @(negedge clk); chk("q_99_bit783", 32'(q), 32'd1);

    load(8'hC3, 98, 1, 1'b1);
    sweep(ones);
    chk("ones_c3", 32'(ones), 32'd392);
    load(8'h93, 98, 2, 1'b1);
    sweep(ones);
    chk("ones_93", 32'(ones), 32'd392);
    @(negedge clk); addr = 10'd4;
    @(negedge clk); chk("q_93_bit4", 32'(q), 32'd1);
    addr = 10'd2;
    @(negedge clk); chk("q_93_bit2", 32'(q), 32'd0);

    // 6a. reset mid-load discards partial image
    r0 = n_ready;
    load(8'hAA, 40, 1, 1'b0);
    chk("pulses_partial", 32'(n_ready - r0), 32'd0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midreset_q", 32'(q), 32'd0);
    r0 = n_ready;
    load(8'h55, 97, 1, 1'b0);
    chk("pulses_97", 32'(n_ready - r0), 32'd0);
    load(8'h55, 1, 2, 1'b1);
    chk("pulses_98", 32'(n_ready - r0), 32'd1);

    // 6b. out-of-range address
    @(negedge clk); addr = 10'd900;
    @(negedge clk); chk("q_addr900", 32'(q), 32'd0);
    addr = 10'd784;
    @(negedge clk); chk("q_addr784", 32'(q), 32'd0);
    addr = 10'd0;
    @(negedge clk); chk("q_addr0_55", 32'(q), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
